// File: rtl/quad_step_ctrl.sv
// Quadrature encoder front end for the 16-bit up/down counter: sync + filter, step FSM, load strobe.
// Build option: define QDEC_X4_EN for x4 decoding (strobe on every legal edge); default is x1.
module quad_step_ctrl #(
  parameter int FILT_LEN = 4,
  parameter int WIDTH    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enc_a,
  input  logic             i_enc_b,
  input  logic             i_ld_req,
  input  logic [WIDTH-1:0] i_preset,
  input  logic             i_err_clr,
  output logic             o_count_enb,
  output logic             o_updn_cnt,
  output logic             o_ld_cnt,
  output logic [WIDTH-1:0] o_data_in,
  output logic             o_err
);

  localparam int CW = 4;
  localparam int IW = 5;
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);
  // INIT waits FILT_LEN+2 stable samples so the synchronizers are flushed before adoption
  localparam logic [IW-1:0] INIT_LAST = IW'(FILT_LEN + 1);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] w_stable;

  assign w_raw = {i_enc_a, i_enc_b};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_phase
      logic          r_sync1;
      logic          r_sync2;
      logic          r_filt;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_filt  <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_filt) begin
            r_cnt <= '0;
          end else if (r_cnt == FILT_LAST) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_filt[gi]   = r_filt;
      assign w_stable[gi] = (r_sync2 == r_filt);
    end
  endgenerate

  state_t        r_state;
  state_t        w_state_next;
  logic [1:0]    r_ref;
  logic [IW-1:0] r_init_cnt;
  logic          r_count_enb;
  logic          r_updn_cnt;
  logic          r_ld_cnt;
  logic [WIDTH-1:0] r_data_in;
  logic          r_err;

  logic       w_adopt;
  logic       w_ref_load;
  logic       w_step;
  logic       w_up;
  logic       w_illegal;
  logic [1:0] w_diff;
  logic [1:0] w_fwd_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:  if (w_adopt) w_state_next = S_TRACK;
      S_TRACK: w_state_next = S_TRACK;
      default: w_state_next = S_INIT;
    endcase
  end

  always_comb begin
    w_adopt    = 1'b0;
    w_ref_load = 1'b0;
    w_step     = 1'b0;
    w_up       = 1'b0;
    w_illegal  = 1'b0;
    w_diff     = w_filt ^ r_ref;
    case (r_ref)
      2'b00:   w_fwd_next = 2'b01;
      2'b01:   w_fwd_next = 2'b11;
      2'b11:   w_fwd_next = 2'b10;
      default: w_fwd_next = 2'b00;
    endcase
    case (r_state)
      S_INIT: begin
        w_adopt    = (&w_stable) && (r_init_cnt == INIT_LAST);
        w_ref_load = w_adopt;
      end
      S_TRACK: begin
        if (w_diff != 2'b00) begin
          w_ref_load = 1'b1;
          if (w_diff == 2'b11) begin
            w_illegal = 1'b1;
          end else begin
            w_up = (w_filt == w_fwd_next);
`ifdef QDEC_X4_EN
            w_step = 1'b1;
`else
            w_step = ((r_ref == 2'b10) && (w_filt == 2'b00)) ||
                     ((r_ref == 2'b00) && (w_filt == 2'b10));
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ref      <= 2'b00;
      r_init_cnt <= '0;
    end else begin
      if (w_ref_load) r_ref <= w_filt;
      if (r_state != S_INIT || !(&w_stable) || w_adopt) begin
        r_init_cnt <= '0;
      end else begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end
    end
  end

  // A load on the same edge as a step wins; the step is dropped but the reference still moves
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count_enb <= 1'b0;
      r_updn_cnt  <= 1'b0;
      r_ld_cnt    <= 1'b1;
      r_data_in   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_count_enb <= w_step & ~i_ld_req;
      if (w_step && !i_ld_req) r_updn_cnt <= w_up;
      r_ld_cnt <= ~i_ld_req;
      if (i_ld_req) r_data_in <= i_preset;
      r_err <= w_illegal | (r_err & ~i_err_clr);
    end
  end

  assign o_count_enb = r_count_enb;
  assign o_updn_cnt  = r_updn_cnt;
  assign o_ld_cnt    = r_ld_cnt;
  assign o_data_in   = r_data_in;
  assign o_err       = r_err;

endmodule

// File: tb/tb_quad_step_ctrl.sv
// Scoreboard bench for quad_step_ctrl: directed encoder/load vectors, monitor compares strobes and loads.
module tb_quad_step_ctrl;

  localparam int FL = 4;
`ifdef QDEC_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_a, enc_b, ld_req, err_clr;
  logic [15:0] preset;
  logic        count_enb, updn_cnt, ld_cnt, err;
  logic [15:0] data_in;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t stb_q[$];
  exp_t ld_q[$];

  quad_step_ctrl #(.FILT_LEN(FL), .WIDTH(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enc_a    (enc_a),
    .i_enc_b    (enc_b),
    .i_ld_req   (ld_req),
    .i_preset   (preset),
    .i_err_clr  (err_clr),
    .o_count_enb(count_enb),
    .o_updn_cnt (updn_cnt),
    .o_ld_cnt   (ld_cnt),
    .o_data_in  (data_in),
    .o_err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d val=%0h", name, cyc, act);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new {a,b}; a change launched after edge k strobes after edge k+FL+3
  task automatic move(input logic [1:0] ab, input int hold, input bit s4, input bit s1, input bit up);
    exp_t e;
    {enc_a, enc_b} = ab;
    if (X4 ? s4 : s1) begin
      e.cyc = cyc + FL + 3;
      e.val = {15'd0, up};
      stb_q.push_back(e);
    end
    wait_cyc(hold);
  endtask

  task automatic load(input logic [15:0] val);
    exp_t e;
    ld_req = 1'b1;
    preset = val;
    e.cyc  = cyc + 1;
    e.val  = val;
    ld_q.push_back(e);
    wait_cyc(1);
    ld_req = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (stb_q.size() > 0 && stb_q[0].cyc < cyc) begin
        e = stb_q.pop_front();
        total++; bad++;
        $display("FAIL strobe_missing cyc=%0d got=none want=strobe@%0d", cyc, e.cyc);
      end
      while (ld_q.size() > 0 && ld_q[0].cyc < cyc) begin
        e = ld_q.pop_front();
        total++; bad++;
        $display("FAIL load_missing cyc=%0d got=none want=load@%0d", cyc, e.cyc);
      end
      if (count_enb) begin
        total++;
        if (stb_q.size() == 0 || stb_q[0].cyc != cyc) begin
          bad++;
          $display("FAIL strobe_unexpected cyc=%0d got=count_enb=1 want=0", cyc);
        end else begin
          e = stb_q.pop_front();
          if (updn_cnt !== e.val[0]) begin
            bad++;
            $display("FAIL strobe_dir cyc=%0d got=%0b want=%0b", cyc, updn_cnt, e.val[0]);
          end else begin
            $display("ok   strobe cyc=%0d updn=%0b", cyc, updn_cnt);
          end
        end
      end
      if (!ld_cnt) begin
        total++;
        if (ld_q.size() == 0 || ld_q[0].cyc != cyc) begin
          bad++;
          $display("FAIL load_unexpected cyc=%0d got=ld_cnt=0 want=1", cyc);
        end else begin
          e = ld_q.pop_front();
          if (data_in !== e.val) begin
            bad++;
            $display("FAIL load_data cyc=%0d got=%0h want=%0h", cyc, data_in, e.val);
          end else begin
            $display("ok   load cyc=%0d data=%0h", cyc, data_in);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; enc_a = 1'b1; enc_b = 1'b1;
    ld_req = 1'b0; err_clr = 1'b0; preset = 16'h0;
    wait_cyc(3);
    chk("rst_count_enb", {31'd0, count_enb}, 32'd0);
    chk("rst_updn_cnt",  {31'd0, updn_cnt},  32'd0);
    chk("rst_ld_cnt",    {31'd0, ld_cnt},    32'd1);
    chk("rst_data_in",   {16'd0, data_in},   32'd0);
    chk("rst_err",       {31'd0, err},       32'd0);
    rst_n = 1'b1;
    wait_cyc(FL + 3);
    chk("init_static_err", {31'd0, err}, 32'd0);
    wait_cyc(15);

    // forward from 11, then reverse
    move(2'b10, 10, 1, 0, 1);
    move(2'b00, 10, 1, 1, 1);
    move(2'b01, 10, 1, 0, 1);
    move(2'b11, 10, 1, 0, 1);
    move(2'b01, 10, 1, 0, 0);
    move(2'b00, 10, 1, 0, 0);
    move(2'b10, 10, 1, 1, 0);
    move(2'b11, 10, 1, 0, 0);

    // phase A glitches: 3 cycles filtered out, 4 cycles accepted
    move(2'b01, 3, 0, 0, 0);
    move(2'b11, 10, 0, 0, 0);
    move(2'b01, 4, 1, 0, 0);
    move(2'b11, 10, 1, 0, 1);

    // illegal 00 -> 11
    move(2'b10, 10, 1, 0, 1);
    move(2'b00, 10, 1, 1, 1);
    move(2'b11, 10, 0, 0, 0);
    chk("illegal_err_set", {31'd0, err}, 32'd1);
    wait_cyc(3);
    chk("illegal_err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    wait_cyc(1);
    err_clr = 1'b0;
    chk("err_clr", {31'd0, err}, 32'd0);
    move(2'b10, 10, 1, 0, 1);

    // single load, then ld_req held three cycles
    load(16'hA5A5);
    wait_cyc(3);
    chk("load_data_hold", {16'd0, data_in}, 32'h0000A5A5);
    load(16'h1111);
    load(16'h2222);
    load(16'h3333);
    wait_cyc(3);

    // step 10 -> 00 collides with a load on the same edge: no strobe
    {enc_a, enc_b} = 2'b00;
    wait_cyc(FL + 2);
    load(16'hBEEF);
    wait_cyc(10);
    chk("collision_data", {16'd0, data_in}, 32'h0000BEEF);

    // reset in the middle of a filter count
    {enc_a, enc_b} = 2'b10;
    wait_cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_count_enb", {31'd0, count_enb}, 32'd0);
    chk("midrst_updn_cnt",  {31'd0, updn_cnt},  32'd0);
    chk("midrst_ld_cnt",    {31'd0, ld_cnt},    32'd1);
    chk("midrst_data_in",   {16'd0, data_in},   32'd0);
    chk("midrst_err",       {31'd0, err},       32'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(25);
    move(2'b00, 10, 1, 1, 1);

    wait_cyc(10);
    chk("strobe_queue_empty", stb_q.size(), 32'd0);
    chk("load_queue_empty",   ld_q.size(),  32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
